// File: rtl/aes_kat_sequencer.sv
// aes_kat_sequencer: table-driven AES known-answer self-test. It walks NUM_VECTORS
// table entries, issues each to the AES core, checks the ciphertext and the
// round-trip plaintext, and keeps saturating pass/fail counts, per-key-size
// status and the index of the first failure.
module aes_kat_sequencer #(
  parameter int NUM_VECTORS    = 3,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8,
  localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             loop_en,
  output logic [IDX_W-1:0] vec_idx,
  input  logic [127:0]     vec_plain,
  input  logic [255:0]     vec_key,
  input  logic [1:0]       vec_mode,
  input  logic [127:0]     vec_expect,
  output logic             core_start,
  input  logic             core_ready,
  output logic [127:0]     core_plain,
  output logic [255:0]     core_key,
  output logic [1:0]       core_mode,
  input  logic             core_done,
  input  logic [127:0]     core_cipher,
  input  logic [127:0]     core_decrypt,
  output logic             busy,
  output logic             done,
  output logic             pass_all,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [IDX_W-1:0] first_fail_idx,
  output logic             first_fail_vld,
  output logic [2:0]       mode_pass
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [127:0]     op_expect;
  logic [127:0]     res_cipher, res_decrypt;
  logic             bad_vec;    // illegal mode or core timeout: forced fail in CHECK
  logic [2:0]       mode_fail;  // a vector of this key size has failed during this run
  logic             last_vec, wait_expire, check_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign last_vec    = (vec_idx == LAST_IDX);
  assign wait_expire = !core_done && (tmo_cnt == TMO_W'(1));
  assign check_ok    = !bad_vec && (res_cipher == op_expect) && (res_decrypt == core_plain);

  assign busy       = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign core_start = (state == S_ISSUE);
  assign pass_all   = done && (fail_count == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; enable low holds the current state
  always_comb begin
    state_nxt = state;
    if (enable) begin
      unique case (state)
        S_IDLE, S_DONE: if (start) state_nxt = S_FETCH;
        S_FETCH:        state_nxt = (vec_mode == 2'd3) ? S_CHECK : S_ISSUE;
        S_ISSUE:        if (core_ready) state_nxt = S_WAIT;
        S_WAIT:         if (core_done || wait_expire) state_nxt = S_CHECK;
        S_CHECK:        state_nxt = (last_vec && !loop_en) ? S_DONE : S_FETCH;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  // Operand latching, timeout, scoring and table walk
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vec_idx        <= '0;
      core_plain     <= '0;
      core_key       <= '0;
      core_mode      <= '0;
      op_expect      <= '0;
      bad_vec        <= 1'b0;
      tmo_cnt        <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_vld <= 1'b0;
      mode_pass      <= '0;
      mode_fail      <= '0;
    end else if (enable) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec_idx        <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_vld <= 1'b0;
            mode_pass      <= '0;
            mode_fail      <= '0;
          end
        end
        S_FETCH: begin
          core_plain <= vec_plain;
          core_key   <= vec_key;
          core_mode  <= vec_mode;
          op_expect  <= vec_expect;
          bad_vec    <= (vec_mode == 2'd3);
        end
        S_ISSUE: begin
          if (core_ready) tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
        end
        S_WAIT: begin
          tmo_cnt <= tmo_cnt - TMO_W'(1);
          if (wait_expire) bad_vec <= 1'b1;
        end
        S_CHECK: begin
          if (check_ok) begin
            pass_count <= sat_inc(pass_count);
            if (core_mode != 2'd3 && !mode_fail[core_mode]) mode_pass[core_mode] <= 1'b1;
          end else begin
            fail_count <= sat_inc(fail_count);
            if (!first_fail_vld) begin
              first_fail_vld <= 1'b1;
              first_fail_idx <= vec_idx;
            end
            if (core_mode != 2'd3) begin
              mode_pass[core_mode] <= 1'b0;
              mode_fail[core_mode] <= 1'b1;
            end
          end
          // A wrap starts a fresh pass over the table; only the first-fail marker restarts
          if (last_vec) begin
            if (loop_en) begin
              vec_idx        <= '0;
              first_fail_vld <= 1'b0;
            end
          end else begin
            vec_idx <= vec_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result capture on the core strobe; a strobe after timeout is ignored
  always_ff @(posedge clk) begin
    if (enable && state == S_WAIT && core_done) begin
      res_cipher  <= core_cipher;
      res_decrypt <= core_decrypt;
    end
  end

endmodule

// File: tb/tb_aes_kat_sequencer.sv
// Bench for aes_kat_sequencer: vector ROM and AES core model around the DUT,
// directed FIPS-197 scenarios plus randomized tables, scored by a run-level model.
module tb_aes_kat_sequencer;

  localparam int NV  = 3;
  localparam int TMO = 64;
  localparam int CW  = 4;
  localparam int IW  = 2;

  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] FIPS_K = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic reset, enable, start, loop_en;
  logic [IW-1:0] vec_idx;
  logic [127:0] vec_plain, vec_expect;
  logic [255:0] vec_key;
  logic [1:0] vec_mode;
  logic core_start, core_ready, core_done;
  logic [127:0] core_plain, core_cipher, core_decrypt;
  logic [255:0] core_key;
  logic [1:0] core_mode;
  logic busy, done, pass_all, first_fail_vld;
  logic [CW-1:0] pass_count, fail_count;
  logic [IW-1:0] first_fail_idx;
  logic [2:0] mode_pass;

  // Vector table and core fault controls (written only by the stimulus process)
  logic [127:0] tbl_plain  [NV];
  logic [255:0] tbl_key    [NV];
  logic [1:0]   tbl_mode   [NV];
  logic [127:0] tbl_expect [NV];
  int hang_v, bad_dec_v, stall_req, lat;

  // Core-model state and monitors
  logic pend, prev_start, op_unstable;
  int wait_left, stall_cnt, acc_cnt, start_hi;
  logic [127:0] cap_plain;
  logic [255:0] cap_key;
  logic [1:0] cap_mode;
  logic [IW-1:0] cap_idx;
  logic [385:0] prev_ops;

  // Model results
  int m_pass, m_fail, m_ffi, m_cyc, m_acc;
  logic m_ffv;
  logic [2:0] m_mp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aes_kat_sequencer #(.NUM_VECTORS(NV), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .loop_en(loop_en),
    .vec_idx(vec_idx), .vec_plain(vec_plain), .vec_key(vec_key), .vec_mode(vec_mode),
    .vec_expect(vec_expect), .core_start(core_start), .core_ready(core_ready),
    .core_plain(core_plain), .core_key(core_key), .core_mode(core_mode),
    .core_done(core_done), .core_cipher(core_cipher), .core_decrypt(core_decrypt),
    .busy(busy), .done(done), .pass_all(pass_all), .pass_count(pass_count),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .first_fail_vld(first_fail_vld), .mode_pass(mode_pass)
  );

  function automatic logic [127:0] ct_of(input int m);
    case (m)
      0:       return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1:       return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  function automatic bit key_ok(input logic [255:0] k, input int m);
    case (m)
      0:       return k[255:128] == FIPS_K[255:128];
      1:       return k[255:64] == FIPS_K[255:64];
      2:       return k == FIPS_K;
      default: return 1'b0;
    endcase
  endfunction

  // Combinational vector ROM
  assign vec_plain  = tbl_plain[vec_idx];
  assign vec_key    = tbl_key[vec_idx];
  assign vec_mode   = tbl_mode[vec_idx];
  assign vec_expect = tbl_expect[vec_idx];
  assign core_ready = (stall_cnt >= stall_req);

  // AES core model: answers FIPS-197 operands correctly, anything else with garbage
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= 1'b0; core_done <= 1'b0; wait_left <= 0; stall_cnt <= 0;
      acc_cnt <= 0; start_hi <= 0; op_unstable <= 1'b0; prev_start <= 1'b0;
    end else if (start) begin
      stall_cnt <= 0; acc_cnt <= 0; start_hi <= 0; op_unstable <= 1'b0;
      prev_start <= 1'b0; core_done <= 1'b0;
    end else begin
      core_done  <= 1'b0;
      prev_start <= core_start;
      prev_ops   <= {core_plain, core_key, core_mode};
      if (core_start && prev_start && ({core_plain, core_key, core_mode} != prev_ops))
        op_unstable <= 1'b1;
      if (core_start && acc_cnt == 0) start_hi <= start_hi + 1;
      if (core_start && !core_ready) stall_cnt <= stall_cnt + 1;
      if (pend) begin
        if (wait_left == 1) begin
          pend        <= 1'b0;
          core_done   <= 1'b1;
          core_cipher <= (cap_plain == FIPS_P && key_ok(cap_key, int'(cap_mode)))
                         ? ct_of(int'(cap_mode)) : ~ct_of(int'(cap_mode));
          core_decrypt <= (int'(cap_idx) == bad_dec_v) ? ~cap_plain : cap_plain;
        end
        wait_left <= wait_left - 1;
      end
      if (core_start && core_ready) begin
        acc_cnt   <= acc_cnt + 1;
        pend      <= (int'(vec_idx) != hang_v);
        wait_left <= lat - 1;
        cap_plain <= core_plain;
        cap_key   <= core_key;
        cap_mode  <= core_mode;
        cap_idx   <= vec_idx;
      end
    end
  end

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Run-level expectation: which vectors pass, counts, status flags, run length
  function automatic void model(input int loops);
    int pass_n, fail_n;
    bit seen_ok [3];
    bit seen_bad [3];
    bit first_issue;
    pass_n = 0; fail_n = 0; first_issue = 1'b1;
    for (int m = 0; m < 3; m++) begin seen_ok[m] = 0; seen_bad[m] = 0; end
    m_ffv = 1'b0; m_ffi = 0; m_cyc = 1; m_acc = 0;
    for (int l = 0; l < loops; l++) begin
      for (int v = 0; v < NV; v++) begin
        int m;
        bit ok;
        m = int'(tbl_mode[v]);
        if (m == 3) begin
          ok = 1'b0;
          m_cyc += 2;
        end else begin
          m_acc++;
          m_cyc += 3 + ((v == hang_v) ? TMO : lat) + (first_issue ? stall_req : 0);
          first_issue = 1'b0;
          ok = (v != hang_v) && (v != bad_dec_v) && tbl_plain[v] == FIPS_P &&
               key_ok(tbl_key[v], m) && tbl_expect[v] == ct_of(m);
        end
        if (ok) begin
          pass_n++;
          seen_ok[m] = 1'b1;
        end else begin
          fail_n++;
          if (m < 3) seen_bad[m] = 1'b1;
          if (!m_ffv) begin m_ffv = 1'b1; m_ffi = v; end
        end
        if (v == NV - 1 && l < loops - 1) m_ffv = 1'b0;
      end
    end
    m_pass = (pass_n > 15) ? 15 : pass_n;
    m_fail = (fail_n > 15) ? 15 : fail_n;
    for (int m = 0; m < 3; m++) m_mp[m] = seen_ok[m] && !seen_bad[m];
  endfunction

  task automatic load_fips();
    for (int v = 0; v < NV; v++) begin
      tbl_plain[v] = FIPS_P; tbl_key[v] = FIPS_K;
      tbl_mode[v] = 2'(v); tbl_expect[v] = ct_of(v);
    end
    hang_v = -1; bad_dec_v = -1; stall_req = 0; lat = 12;
  endtask

  task automatic run_case(input string name, input int loops, input int freeze_n);
    int n;
    model(loops);
    loop_en = (loops > 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    check_val({name, "/busy_start"}, 256'(busy), 256'(1));
    if (freeze_n > 0) begin
      enable = 1'b0;
      repeat (freeze_n) begin @(posedge clk); #1; n++; end
      check_val({name, "/frz_busy"}, 256'(busy), 256'(1));
      check_val({name, "/frz_cstart"}, 256'(core_start), 256'(0));
      enable = 1'b1;
    end
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (loops > 1 && n == m_cyc + freeze_n - 20) loop_en = 1'b0;
    end
    check_val({name, "/cycles"}, 256'(n), 256'(m_cyc + freeze_n));
    check_val({name, "/busy_end"}, 256'(busy), 256'(0));
    check_val({name, "/pass_cnt"}, 256'(pass_count), 256'(m_pass));
    check_val({name, "/fail_cnt"}, 256'(fail_count), 256'(m_fail));
    check_val({name, "/ff_vld"}, 256'(first_fail_vld), 256'(m_ffv));
    if (m_ffv) check_val({name, "/ff_idx"}, 256'(first_fail_idx), 256'(m_ffi));
    check_val({name, "/mode_pass"}, 256'(mode_pass), 256'(m_mp));
    check_val({name, "/pass_all"}, 256'(pass_all), 256'(m_fail == 0));
    check_val({name, "/issued"}, 256'(acc_cnt), 256'(m_acc * loops / loops));
    check_val({name, "/start_hold"}, 256'(start_hi), 256'((m_acc > 0) ? stall_req + 1 : 0));
    check_val({name, "/op_stable"}, 256'(op_unstable), 256'(0));
  endtask

  task automatic check_zero(input string name);
    check_val({name, "/busy"}, 256'(busy), 256'(0));
    check_val({name, "/done"}, 256'(done), 256'(0));
    check_val({name, "/pass_all"}, 256'(pass_all), 256'(0));
    check_val({name, "/cstart"}, 256'(core_start), 256'(0));
    check_val({name, "/idx"}, 256'(vec_idx), 256'(0));
    check_val({name, "/cnts"}, 256'({pass_count, fail_count}), 256'(0));
    check_val({name, "/ff"}, 256'({first_fail_vld, first_fail_idx}), 256'(0));
    check_val({name, "/mode_pass"}, 256'(mode_pass), 256'(0));
    check_val({name, "/ops"}, 256'(core_plain ^ core_key[255:128] ^ core_key[127:0]), 256'(0));
    check_val({name, "/cmode"}, 256'(core_mode), 256'(0));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; start = 1'b0; loop_en = 1'b0;
    load_fips();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    load_fips();
    run_case("fips", 1, 0);

    load_fips();
    tbl_expect[1] = tbl_expect[1] ^ 128'h1;
    run_case("bad_expect", 1, 0);

    load_fips();
    hang_v = 0;
    run_case("timeout", 1, 0);

    load_fips();
    stall_req = 5;
    run_case("stall", 1, 0);

    load_fips();
    bad_dec_v = 2;
    run_case("bad_decrypt", 1, 0);

    // Reset pulsed in the middle of vector 0's WAIT
    load_fips();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_zero("rst_async");
    @(posedge clk); #1;
    check_zero("rst_next");
    reset = 1'b1;
    @(posedge clk); #1;
    run_case("after_rst", 1, 0);

    load_fips();
    run_case("loop_sat", 6, 0);

    load_fips();
    tbl_mode[2] = 2'd3;
    run_case("illegal", 1, 0);

    load_fips();
    run_case("freeze", 1, 4);

    for (int r = 0; r < 10; r++) begin
      load_fips();
      lat = $urandom_range(2, 16);
      stall_req = $urandom_range(0, 4);
      for (int v = 0; v < NV; v++) begin
        tbl_mode[v] = 2'($urandom_range(0, 3));
        tbl_expect[v] = ct_of(int'(tbl_mode[v]));
        if ($urandom_range(0, 4) == 0) tbl_expect[v] = tbl_expect[v] ^ 128'({$urandom} | 32'h1);
        if ($urandom_range(0, 5) == 0) tbl_plain[v] = tbl_plain[v] ^ {96'h0, ($urandom | 32'h1)};
        if ($urandom_range(0, 1) == 0) tbl_key[v][63:0] = {$urandom, ($urandom | 32'h1)};
      end
      if ($urandom_range(0, 3) == 0) hang_v = $urandom_range(0, NV - 1);
      if ($urandom_range(0, 3) == 0) bad_dec_v = $urandom_range(0, NV - 1);
      run_case($sformatf("rand%0d", r), 1, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
